// File: rtl/filtrado_pkg.sv
// Shared encodings for the three-band filter sequencer: FSM states, band codes
// and the default number of MAC taps per band.
package filtrado_pkg;

  localparam int N_BANDS    = 3;
  localparam int N_TAPS_DEF = 3;

  localparam logic [1:0] BAND_B = 2'd0;
  localparam logic [1:0] BAND_M = 2'd1;
  localparam logic [1:0] BAND_A = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    SUM  = 2'd3
  } state_t;

endpackage

// File: rtl/sel_banda_sig.sv
// Picks the next enabled band: from band 0 inclusive when start is set,
// otherwise the first enabled band strictly above band_cur.
module sel_banda_sig
  import filtrado_pkg::*;
(
  input  logic [2:0] mask,
  input  logic [1:0] band_cur,
  input  logic       start,
  output logic [1:0] band_sig,
  output logic       none
);

  // Scan downwards so the lowest qualifying band is the one left standing.
  always_comb begin
    band_sig = BAND_B;
    none     = 1'b1;
    for (int i = N_BANDS - 1; i >= 0; i--) begin
      if (mask[i] && (start || (i > int'(band_cur)))) begin
        band_sig = 2'(i);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/control_filtrado.sv
// Sequencer for the shared MAC of the B/M/A filter bands.
// Optional one-deep strobe queue: define CONTROL_FILTRADO_PENDING_EN.
//
// state | meaning
// IDLE  | waiting for a sample strobe
// MAC   | stepping taps of the active band through the MAC
// WB    | writing back the active band's accumulator
// SUM   | registering y from the enabled band outputs
module control_filtrado
  import filtrado_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int TAP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             sw_B,
  input  logic             sw_M,
  input  logic             sw_A,
  output logic             busy,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [1:0]       band,
  output logic [TAP_W-1:0] tap,
  output logic             wb,
  output logic             sum_en,
  output logic             y_valid,
  output logic             overrun
);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

  state_t           state, state_n;
  logic [1:0]       band_r, band_n;
  logic [TAP_W-1:0] tap_r, tap_n;
  logic [2:0]       en_r, en_n;
  logic             yv_r;
  logic             ov_r, ov_n;
  logic             launch;

  logic [2:0] sw_mask;
  logic [2:0] ini_mask;
  logic [1:0] ini_band, wb_band;
  logic       ini_none, wb_none;

  assign sw_mask = {sw_A, sw_M, sw_B};

`ifdef CONTROL_FILTRADO_PENDING_EN
  logic       pend_r, pend_n;
  logic [2:0] pmask_r, pmask_n;

  // Leaving SUM, a queued sample takes priority over a fresh strobe.
  assign ini_mask = (state == SUM && pend_r) ? pmask_r : sw_mask;
`else
  assign ini_mask = sw_mask;
`endif

  sel_banda_sig u_sel_ini (
    .mask     (ini_mask),
    .band_cur (BAND_B),
    .start    (1'b1),
    .band_sig (ini_band),
    .none     (ini_none)
  );

  sel_banda_sig u_sel_wb (
    .mask     (en_r),
    .band_cur (band_r),
    .start    (1'b0),
    .band_sig (wb_band),
    .none     (wb_none)
  );

  always_comb begin
    state_n = state;
    band_n  = band_r;
    tap_n   = tap_r;
    en_n    = en_r;
    ov_n    = ov_r;
    launch  = 1'b0;
`ifdef CONTROL_FILTRADO_PENDING_EN
    pend_n  = pend_r;
    pmask_n = pmask_r;
`endif

    case (state)
      IDLE: launch = rx;
      MAC: begin
        if (tap_r == TAP_LAST) begin
          state_n = WB;
          tap_n   = '0;
        end else begin
          tap_n = tap_r + 1'b1;
        end
      end
      WB: begin
        if (wb_none) begin
          state_n = SUM;
          band_n  = BAND_B;
        end else begin
          state_n = MAC;
          band_n  = wb_band;
        end
      end
      SUM: begin
        state_n = IDLE;
`ifdef CONTROL_FILTRADO_PENDING_EN
        launch  = pend_r || rx;
        pend_n  = 1'b0;
`endif
      end
      default: state_n = IDLE;
    endcase

    if (launch) begin
      en_n  = ini_mask;
      tap_n = '0;
      if (ini_none) begin
        state_n = SUM;
        band_n  = BAND_B;
      end else begin
        state_n = MAC;
        band_n  = ini_band;
      end
    end

    if (rx && state != IDLE) begin
`ifdef CONTROL_FILTRADO_PENDING_EN
      if (pend_r) begin
        ov_n = 1'b1;
      end else if (state != SUM) begin
        pend_n  = 1'b1;
        pmask_n = sw_mask;
      end
`else
      ov_n = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      band_r  <= BAND_B;
      tap_r   <= '0;
      en_r    <= 3'b000;
      yv_r    <= 1'b0;
      ov_r    <= 1'b0;
`ifdef CONTROL_FILTRADO_PENDING_EN
      pend_r  <= 1'b0;
      pmask_r <= 3'b000;
`endif
    end else begin
      state   <= state_n;
      band_r  <= band_n;
      tap_r   <= tap_n;
      en_r    <= en_n;
      yv_r    <= (state == SUM);
      ov_r    <= ov_n;
`ifdef CONTROL_FILTRADO_PENDING_EN
      pend_r  <= pend_n;
      pmask_r <= pmask_n;
`endif
    end
  end

  assign busy    = (state != IDLE);
  assign mac_en  = (state == MAC);
  assign mac_clr = (state == MAC) && (tap_r == '0);
  assign wb      = (state == WB);
  assign sum_en  = (state == SUM);
  assign band    = band_r;
  assign tap     = tap_r;
  assign y_valid = yv_r;
  assign overrun = ov_r;

endmodule

// File: tb/tb_control_filtrado.sv
// Self-checking bench for control_filtrado: directed table, hand sequences and
// randomized strobes against a schedule-level reference model.
module tb_control_filtrado;

  localparam int NT   = 3;
  localparam int MAXC = 1700;
`ifdef CONTROL_FILTRADO_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rx, sw_B, sw_M, sw_A;
  logic busy, mac_clr, mac_en, wb, sum_en, y_valid, overrun;
  logic [1:0] band;
  logic [2:0] tap;

  int errors = 0;
  int checks = 0;

  control_filtrado #(.N_TAPS(NT), .TAP_W(3)) dut (
    .clk(clk), .rst(rst), .rx(rx), .sw_B(sw_B), .sw_M(sw_M), .sw_A(sw_A),
    .busy(busy), .mac_clr(mac_clr), .mac_en(mac_en), .band(band), .tap(tap),
    .wb(wb), .sum_en(sum_en), .y_valid(y_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // stimulus and per-cycle expectations for the model-driven runs
  logic       stim_rx [MAXC];
  logic [2:0] stim_m  [MAXC];
  logic       e_busy [MAXC], e_clr [MAXC], e_mac [MAXC], e_wb [MAXC];
  logic       e_sum  [MAXC], e_yv  [MAXC], e_ov  [MAXC];
  logic [1:0] e_band [MAXC];
  logic [2:0] e_tap  [MAXC];
  int yv_count;

  typedef struct {
    logic [2:0] m;
    int         lat;
    int         n_mac;
    int         n_wb;
    logic [1:0] first_band;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [11:0] outs();
    return {busy, mac_clr, mac_en, band, tap, wb, sum_en, y_valid, overrun};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; rx = 1'b0; {sw_A, sw_M, sw_B} = 3'b000;
    @(negedge clk);
    check("reset_outputs", int'(outs()), 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // A sample accepted at cycle c runs each enabled band for NT MAC cycles plus
  // one write-back, then one SUM cycle; y_valid follows SUM.
  task automatic sched(input int c, input logic [2:0] m, output int s);
    int k = 0;
    for (int b = 0; b < 3; b++) begin
      if (m[b]) begin
        int st = c + 1 + k * (NT + 1);
        for (int t = 0; t < NT; t++) begin
          e_mac[st+t]  = 1'b1;
          e_clr[st+t]  = (t == 0);
          e_band[st+t] = 2'(b);
          e_tap[st+t]  = 3'(t);
        end
        e_wb[st+NT]   = 1'b1;
        e_band[st+NT] = 2'(b);
        k++;
      end
    end
    s = c + 1 + k * (NT + 1);
    e_sum[s]  = 1'b1;
    e_yv[s+1] = 1'b1;
    for (int i = c + 1; i <= s; i++) e_busy[i] = 1'b1;
  endtask

  task automatic set_ov(input int from);
    for (int j = from; j < MAXC; j++) e_ov[j] = 1'b1;
  endtask

  task automatic model_build(input int len);
    int bu = -1;
    logic pend = 1'b0;
    logic [2:0] pm = 3'b000;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_clr[i] = 0; e_mac[i] = 0; e_wb[i] = 0;
      e_sum[i] = 0; e_yv[i] = 0; e_ov[i] = 0; e_band[i] = 0; e_tap[i] = 0;
    end
    for (int c = 0; c < len; c++) begin
      if (c > bu) begin
        if (stim_rx[c]) sched(c, stim_m[c], bu);
      end else if (c == bu && PEND) begin
        if (pend) begin
          pend = 1'b0;
          if (stim_rx[c]) set_ov(c + 1);
          sched(c, pm, bu);
        end else if (stim_rx[c]) begin
          sched(c, stim_m[c], bu);
        end
      end else if (stim_rx[c]) begin
        if (PEND && !pend) begin
          pend = 1'b1;
          pm = stim_m[c];
        end else begin
          set_ov(c + 1);
        end
      end
    end
  endtask

  task automatic run_engine(input int len, input string name);
    logic [11:0] exp;
    do_reset();
    model_build(len);
    yv_count = 0;
    for (int c = 0; c < len + 16; c++) begin
      rx = (c < len) ? stim_rx[c] : 1'b0;
      {sw_A, sw_M, sw_B} = stim_m[c];
      @(negedge clk);
      exp = {e_busy[c], e_clr[c], e_mac[c], e_band[c], e_tap[c],
             e_wb[c], e_sum[c], e_yv[c], e_ov[c]};
      checks++;
      if (outs() != exp) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%b expected=%b", name, c, outs(), exp);
      end
      if (y_valid) yv_count++;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      stim_rx[i] = 1'b0;
      stim_m[i]  = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    int lat, n_mac, n_wb, cyc;
    logic [1:0] b1;
    logic busy_at_yv;

    vecs[0] = '{3'b111, 14, 9, 3, 2'd0};
    vecs[1] = '{3'b010,  6, 3, 1, 2'd1};
    vecs[2] = '{3'b000,  2, 0, 0, 2'd0};
    vecs[3] = '{3'b001,  6, 3, 1, 2'd0};
    vecs[4] = '{3'b100,  6, 3, 1, 2'd2};
    vecs[5] = '{3'b101, 10, 6, 2, 2'd0};
    vecs[6] = '{3'b110, 10, 6, 2, 2'd1};
    vecs[7] = '{3'b011, 10, 6, 2, 2'd0};

    // Single-sample table: latency, MAC/WB counts, starting band.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      rx = 1'b1; {sw_A, sw_M, sw_B} = vecs[v].m;
      @(posedge clk); #1;
      rx = 1'b0; {sw_A, sw_M, sw_B} = ~vecs[v].m;
      lat = -1; n_mac = 0; n_wb = 0; b1 = 2'd3; busy_at_yv = 1'b1;
      cyc = 1;
      while (cyc < 40 && lat < 0) begin
        @(negedge clk);
        if (cyc == 1) b1 = band;
        if (mac_en) n_mac++;
        if (wb) n_wb++;
        if (y_valid) begin
          lat = cyc;
          busy_at_yv = busy;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("latency_m%b", vecs[v].m), lat, vecs[v].lat);
      check($sformatf("mac_count_m%b", vecs[v].m), n_mac, vecs[v].n_mac);
      check($sformatf("wb_count_m%b", vecs[v].m), n_wb, vecs[v].n_wb);
      check($sformatf("first_band_m%b", vecs[v].m), int'(b1), int'(vecs[v].first_band));
      check($sformatf("busy_at_yvalid_m%b", vecs[v].m), int'(busy_at_yv), 0);
    end

    // Second strobe at cycle 6 while the first sample is still running.
    clear_stim();
    stim_rx[0] = 1'b1; stim_m[0] = 3'b111;
    stim_rx[6] = 1'b1; stim_m[6] = 3'b111;
    run_engine(40, "busy_strobe");
    check("busy_strobe_yvalid_count", yv_count, PEND ? 2 : 1);
    check("busy_strobe_overrun", int'(overrun), PEND ? 0 : 1);

    // Back-to-back samples every 16 cycles.
    clear_stim();
    for (int i = 0; i < 100; i++) begin
      stim_rx[i*16] = 1'b1;
      stim_m[i*16]  = 3'b111;
    end
    run_engine(1600, "stream16");
    check("stream16_yvalid_count", yv_count, 100);
    check("stream16_overrun", int'(overrun), 0);

    // Random strobes and enables.
    clear_stim();
    for (int i = 0; i < 800; i++) stim_rx[i] = ($urandom_range(0, 5) == 0);
    run_engine(800, "random");

    // Asynchronous reset in the middle of the mid-band MAC run.
    do_reset();
    rx = 1'b1; {sw_A, sw_M, sw_B} = 3'b111;
    @(posedge clk); #1;
    rx = 1'b0;
    for (int i = 1; i < 7; i++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", int'(outs()), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("no_wb_after_abort", int'(wb), 0);
    check("idle_after_abort", int'(outs()), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    rx = 1'b1; {sw_A, sw_M, sw_B} = 3'b111;
    @(posedge clk); #1;
    rx = 1'b0;
    @(negedge clk);
    check("restart_mac_clr", int'(mac_clr), 1);
    check("restart_band", int'(band), 0);
    check("restart_tap", int'(tap), 0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
